// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO block: register indices and
// byte-lane helpers used by the write path.
package wb_gpio_pkg;

    typedef enum logic [2:0] {
        REG_OUT      = 3'd0,
        REG_IN       = 3'd1,
        REG_RISE_EN  = 3'd2,
        REG_FALL_EN  = 3'd3,
        REG_PENDING  = 3'd4,
        REG_OUT_SET  = 3'd5,
        REG_OUT_CLR  = 3'd6,
        REG_UNMAPPED = 3'd7
    } reg_idx_e;

    // Expand the four byte selects into a 32-bit bit mask.
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{sel[b]}};
        end
        return mask;
    endfunction

    // Replace only the selected byte lanes of old_word with new_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] mask;
        mask = sel_mask(sel);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: synchroniser chain, counter-based debouncer and
// single-cycle rise/fall strobes that coincide with the debounced update.
module gpio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   state_reg;
    logic [CW-1:0]          count_reg;
    logic                   synced;
    logic                   differ;
    logic                   accept;

    assign synced = sync_reg[SYNC_STAGES-1];
    assign differ = synced ^ state_reg;
    // The change is accepted on the edge where the counter would pass LAST,
    // so the strobes line up with the state toggle.
    assign accept = differ && (count_reg == LAST);

    assign level = state_reg;
    assign rise  = accept & ~state_reg;
    assign fall  = accept &  state_reg;

    // Shift the asynchronous pin through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= 1'b0;
            count_reg <= '0;
        end else if (accept) begin
            state_reg <= ~state_reg;
            count_reg <= '0;
        end else if (differ) begin
            count_reg <= count_reg + 1'b1;
        end else begin
            count_reg <= '0;
        end
    end

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO slave: output register with atomic set/clear, debounced
// inputs with enabled edge capture into sticky pending bits, level irq.
module wb_gpio
    import wb_gpio_pkg::*;
#(
    parameter int NIN             = 8,
    parameter int NOUT            = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    input  logic            wb_we,
    input  logic [2:0]      wb_adr,
    input  logic [3:0]      wb_sel,
    input  logic [31:0]     wb_dat_i,
    output logic [31:0]     wb_dat_o,
    output logic            wb_ack,
    output logic            wb_stall,
    input  logic [NIN-1:0]  gpio_i,
    output logic [NOUT-1:0] gpio_o,
    output logic            irq
);

    logic [NOUT-1:0] out_reg, out_next;
    logic [NIN-1:0]  rise_en_reg, rise_en_next;
    logic [NIN-1:0]  fall_en_reg, fall_en_next;
    logic [NIN-1:0]  pending_reg, pending_next;
    logic            ack_reg;
    logic [31:0]     dat_reg, dat_next;

    logic [NIN-1:0]  in_state;
    logic [NIN-1:0]  rise;
    logic [NIN-1:0]  fall;
    logic [NIN-1:0]  edge_set;

    logic            req;
    logic            write_en;
    reg_idx_e        adr_idx;
    logic [31:0]     wmask;
    logic [31:0]     out_ext, in_ext, rise_en_ext, fall_en_ext, pending_ext;
    logic [31:0]     out_word, rise_word, fall_word, clr_word, rd_word;
    logic            unused_bits;

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_in
            gpio_debounce #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .pin  (gpio_i[gi]),
                .level(in_state[gi]),
                .rise (rise[gi]),
                .fall (fall[gi])
            );
        end
    endgenerate

    assign req      = wb_cyc & wb_stb;
    assign write_en = req & wb_we;
    assign adr_idx  = reg_idx_e'(wb_adr);
    assign wmask    = sel_mask(wb_sel);

    assign out_ext     = 32'(out_reg);
    assign in_ext      = 32'(in_state);
    assign rise_en_ext = 32'(rise_en_reg);
    assign fall_en_ext = 32'(fall_en_reg);
    assign pending_ext = 32'(pending_reg);

    assign edge_set = (rise & rise_en_reg) | (fall & fall_en_reg);

    // Register write decode; hardware edge sets are OR-ed in after the W1C
    // clear so a same-cycle set always survives.
    always_comb begin
        out_word  = out_ext;
        rise_word = rise_en_ext;
        fall_word = fall_en_ext;
        clr_word  = '0;
        if (write_en) begin
            case (adr_idx)
                REG_OUT:     out_word  = byte_merge(out_ext, wb_dat_i, wb_sel);
                REG_RISE_EN: rise_word = byte_merge(rise_en_ext, wb_dat_i, wb_sel);
                REG_FALL_EN: fall_word = byte_merge(fall_en_ext, wb_dat_i, wb_sel);
                REG_PENDING: clr_word  = wb_dat_i & wmask;
                REG_OUT_SET: out_word  = out_ext | (wb_dat_i & wmask);
                REG_OUT_CLR: out_word  = out_ext & ~(wb_dat_i & wmask);
                default:     ;
            endcase
        end
        out_next     = out_word[NOUT-1:0];
        rise_en_next = rise_word[NIN-1:0];
        fall_en_next = fall_word[NIN-1:0];
        pending_next = (pending_reg & ~clr_word[NIN-1:0]) | edge_set;
    end

    // Read mux samples register state in the request cycle; non-reads return 0.
    always_comb begin
        rd_word = '0;
        case (adr_idx)
            REG_OUT:     rd_word = out_ext;
            REG_IN:      rd_word = in_ext;
            REG_RISE_EN: rd_word = rise_en_ext;
            REG_FALL_EN: rd_word = fall_en_ext;
            REG_PENDING: rd_word = pending_ext;
            default:     rd_word = '0;
        endcase
        dat_next = (req && !wb_we) ? rd_word : '0;
    end

    // Bits above NIN/NOUT in the merged words are intentionally dropped.
    assign unused_bits = ^{out_word, rise_word, fall_word, clr_word};

    // Register file and bus response.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg     <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            pending_reg <= '0;
            ack_reg     <= 1'b0;
            dat_reg     <= '0;
        end else begin
            out_reg     <= out_next;
            rise_en_reg <= rise_en_next;
            fall_en_reg <= fall_en_next;
            pending_reg <= pending_next;
            ack_reg     <= req;
            dat_reg     <= dat_next;
        end
    end

    assign wb_ack   = ack_reg;
    assign wb_dat_o = dat_reg;
    assign wb_stall = 1'b0;
    assign gpio_o   = out_reg;
    assign irq      = |pending_reg;

endmodule

// File: tb/tb_wb_gpio.sv
// Self-checking bench for wb_gpio: table-driven register accesses plus
// hand-timed sequences for debounce latency, edge capture and reset.
module tb_wb_gpio;
    import wb_gpio_pkg::*;

    localparam int NIN  = 4;
    localparam int NOUT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wb_cyc = 1'b0;
    logic            wb_stb = 1'b0;
    logic            wb_we = 1'b0;
    logic [2:0]      wb_adr = 3'd0;
    logic [3:0]      wb_sel = 4'h0;
    logic [31:0]     wb_dat_i = 32'h0;
    logic [31:0]     wb_dat_o;
    logic            wb_ack;
    logic            wb_stall;
    logic [NIN-1:0]  gpio_i = '0;
    logic [NOUT-1:0] gpio_o;
    logic            irq;

    always #5 clk = ~clk;

    wb_gpio #(
        .NIN(NIN), .NOUT(NOUT), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack), .wb_stall(wb_stall), .gpio_i(gpio_i), .gpio_o(gpio_o),
        .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected read data, one entry per issued request.
    typedef struct {
        logic [31:0] data;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    bit   mon_en = 1'b0;
    logic req_d  = 1'b0;

    // Reference ack timing: one cycle after each sampled request, none in reset.
    always @(posedge clk) req_d <= rst ? 1'b0 : (wb_cyc & wb_stb);

    // Response monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("ack_timing", {31'b0, wb_ack}, {31'b0, req_d});
            check("stall", {31'b0, wb_stall}, 32'h0);
            if (wb_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with data 0x%0h required no ack", wb_dat_o);
                end else begin
                    e = sb_q.pop_front();
                    $display("ack %s data 0x%0h", e.tag, wb_dat_o);
                    check(e.tag, wb_dat_o, e.data);
                end
            end else begin
                check("dat_idle", wb_dat_o, 32'h0);
            end
            if (rst) sb_q.delete();
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request for one cycle; writes expect zero data back.
    task automatic bus_issue(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, input logic [31:0] rd, input string tag);
        exp_t e;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
        e.data = we ? 32'h0 : rd;
        e.tag  = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_dat_i = 32'h0; wb_sel = 4'h0;
    endtask

    task automatic single(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input logic [31:0] rd, input string tag);
        bus_issue(we, adr, sel, dat, rd, tag);
        bus_idle();
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] rd;
        logic [3:0]  gpio;
        string       name;
    } vec_t;
    vec_t vecs[17];

    initial begin
        vecs[0]  = '{1'b1, REG_OUT,      4'hF, 32'h0000000A, 32'h0, 4'hA, "wr_out_a"};
        vecs[1]  = '{1'b1, REG_OUT_SET,  4'hF, 32'h00000001, 32'h0, 4'hB, "set_1"};
        vecs[2]  = '{1'b1, REG_OUT_CLR,  4'hF, 32'h00000008, 32'h0, 4'h3, "clr_8"};
        vecs[3]  = '{1'b0, REG_OUT,      4'hF, 32'h0,        32'h3, 4'h3, "rd_out_3"};
        vecs[4]  = '{1'b1, REG_OUT,      4'h2, 32'hFFFFFFFF, 32'h0, 4'h3, "wr_out_sel2"};
        vecs[5]  = '{1'b1, REG_OUT,      4'h1, 32'hFFFFFFFF, 32'h0, 4'hF, "wr_out_sel1"};
        vecs[6]  = '{1'b0, REG_OUT,      4'hF, 32'h0,        32'hF, 4'hF, "rd_out_f"};
        vecs[7]  = '{1'b0, REG_OUT_SET,  4'hF, 32'h0,        32'h0, 4'hF, "rd_out_set"};
        vecs[8]  = '{1'b1, REG_RISE_EN,  4'hF, 32'h000000FF, 32'h0, 4'hF, "wr_rise_ff"};
        vecs[9]  = '{1'b0, REG_RISE_EN,  4'hF, 32'h0,        32'hF, 4'hF, "rd_rise_f"};
        vecs[10] = '{1'b0, REG_OUT_CLR,  4'hF, 32'h0,        32'h0, 4'hF, "rd_out_clr"};
        vecs[11] = '{1'b1, REG_RISE_EN,  4'hF, 32'h00000001, 32'h0, 4'hF, "wr_rise_1"};
        vecs[12] = '{1'b1, REG_FALL_EN,  4'hF, 32'h00000002, 32'h0, 4'hF, "wr_fall_2"};
        vecs[13] = '{1'b0, REG_FALL_EN,  4'hF, 32'h0,        32'h2, 4'hF, "rd_fall_2"};
        vecs[14] = '{1'b0, REG_IN,       4'hF, 32'h0,        32'h0, 4'hF, "rd_in_0"};
        vecs[15] = '{1'b1, REG_UNMAPPED, 4'hF, 32'hFFFFFFFF, 32'h0, 4'hF, "wr_idx7"};
        vecs[16] = '{1'b0, REG_UNMAPPED, 4'hF, 32'h0,        32'h0, 4'hF, "rd_idx7"};

        // Reset state.
        wait_cycles(3);
        check("rst_gpio", {28'b0, gpio_o}, 32'h0);
        check("rst_ack", {31'b0, wb_ack}, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        wait_cycles(1);

        // Table-driven register accesses; gpio_o checked alongside the ack.
        for (int i = 0; i < 17; i++) begin
            bus_issue(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].rd, vecs[i].name);
            bus_idle();
            @(negedge clk);
            check({vecs[i].name, "_gpio"}, {28'b0, gpio_o}, {28'b0, vecs[i].gpio});
            @(posedge clk);
            #1;
        end

        // Glitch of 3 cycles is rejected.
        gpio_i[0] = 1'b1;
        wait_cycles(3);
        gpio_i[0] = 1'b0;
        wait_cycles(10);
        single(1'b0, REG_IN, 4'hF, 32'h0, 32'h0, "glitch_in");
        single(1'b0, REG_PENDING, 4'hF, 32'h0, 32'h0, "glitch_pend");
        wait_cycles(2);

        // Held high: accepted on the 6th edge after the pin change.
        gpio_i[0] = 1'b1;
        wait_cycles(5);
        check("irq_before_accept", {31'b0, irq}, 32'h0);
        bus_issue(1'b0, REG_IN, 4'hF, 32'h0, 32'h0, "in_edge6_pre");
        check("irq_at_accept", {31'b0, irq}, 32'h1);
        bus_issue(1'b0, REG_IN, 4'hF, 32'h0, 32'h1, "in_edge7_post");
        bus_idle();
        wait_cycles(1);
        single(1'b0, REG_PENDING, 4'hF, 32'h0, 32'h1, "pend_rise0");
        wait_cycles(1);

        // Ch1 rise is not enabled; ch1 fall is.
        gpio_i[1] = 1'b1;
        wait_cycles(10);
        single(1'b0, REG_PENDING, 4'hF, 32'h0, 32'h1, "pend_rise1_ignored");
        single(1'b0, REG_IN, 4'hF, 32'h0, 32'h3, "in_3");
        gpio_i[1] = 1'b0;
        wait_cycles(10);
        single(1'b0, REG_PENDING, 4'hF, 32'h0, 32'h3, "pend_fall1");
        check("irq_pend3", {31'b0, irq}, 32'h1);
        single(1'b1, REG_PENDING, 4'hF, 32'h1, 32'h0, "w1c_1");
        single(1'b0, REG_PENDING, 4'hF, 32'h0, 32'h2, "pend_2");
        check("irq_pend2", {31'b0, irq}, 32'h1);
        single(1'b1, REG_PENDING, 4'hF, 32'h2, 32'h0, "w1c_2");
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // Collision: W1C of bit0 on the edge that accepts a ch0 rise.
        gpio_i[0] = 1'b0;
        wait_cycles(10);
        single(1'b0, REG_PENDING, 4'hF, 32'h0, 32'h0, "pend_fall0_ignored");
        wait_cycles(1);
        gpio_i[0] = 1'b1;
        wait_cycles(5);
        bus_issue(1'b1, REG_PENDING, 4'hF, 32'h1, 32'h0, "w1c_collide");
        bus_idle();
        check("irq_collide", {31'b0, irq}, 32'h1);
        wait_cycles(1);
        single(1'b0, REG_PENDING, 4'hF, 32'h0, 32'h1, "pend_collide");
        wait_cycles(1);

        // Pipelined burst of four reads.
        bus_issue(1'b0, REG_IN,       4'hF, 32'h0, 32'h1, "burst_in");
        bus_issue(1'b0, REG_RISE_EN,  4'hF, 32'h0, 32'h1, "burst_rise");
        bus_issue(1'b0, REG_PENDING,  4'hF, 32'h0, 32'h1, "burst_pend");
        bus_issue(1'b0, REG_UNMAPPED, 4'hF, 32'h0, 32'h0, "burst_idx7");
        bus_idle();
        wait_cycles(2);

        // Reset asserted in the middle of a burst.
        bus_issue(1'b0, REG_OUT,     4'hF, 32'h0, 32'hF, "pre_rst_out");
        bus_issue(1'b0, REG_RISE_EN, 4'hF, 32'h0, 32'h1, "pre_rst_rise");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ack", {31'b0, wb_ack}, 32'h0);
        check("midrst_gpio", {28'b0, gpio_o}, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        bus_idle();
        wait_cycles(2);
        rst = 1'b0;

        // Pin held high through reset is accepted as a rise; enables are cleared.
        wait_cycles(10);
        single(1'b0, REG_IN, 4'hF, 32'h0, 32'h1, "post_rst_in");
        single(1'b0, REG_PENDING, 4'hF, 32'h0, 32'h0, "post_rst_pend");
        single(1'b0, REG_OUT, 4'hF, 32'h0, 32'h0, "post_rst_out");
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        wait_cycles(3);
        check("sb_drained", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/wb_gpio.md
Name: wb_gpio

Overview:
- Parametrised Wishbone GPIO slave for LED/switch/button pins; replaces fixed-width direct pin wiring in the SoC.
- NOUT registered outputs (LEDs) with atomic set/clear registers.
- NIN inputs (switches/buttons), each synchronised, debounced and edge-detected.
- Rise/fall edge capture into sticky pending bits; one level interrupt to the core.

Parameters:
- NIN, 8, number of input channels (1..32).
- NOUT, 8, number of output channels (1..32).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before an input change is accepted (>=1; 1 = no filtering).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wb_cyc  in  1  Wishbone cycle.
- wb_stb  in  1  Wishbone strobe.
- wb_we  in  1  write enable.
- wb_adr  in  3  word address (byte address bits [4:2]).
- wb_sel  in  4  byte selects.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack  out  1  acknowledge.
- wb_stall  out  1  pipeline stall, tied 0.
- gpio_i  in  NIN  asynchronous pin inputs.
- gpio_o  out  NOUT  output pins (= OUT register).
- irq  out  1  interrupt, = |PENDING.

Behaviour:
- Reset: gpio_o=0, wb_ack=0, wb_dat_o=0, irq=0. All registers, synchronisers, debounced state and counters = 0.
- Bus protocol: pipelined Wishbone, stall never asserted.
  - wb_ack=1 exactly one cycle after each cycle with wb_cyc&wb_stb; back-to-back requests give back-to-back acks.
  - wb_dat_o is registered and valid with ack. It holds 0 when no read is acked.
  - Reads sample register state at the request cycle.
- Register map (word index). Bits above NIN/NOUT read 0 and ignore writes.
  - 0 OUT: rw, NOUT bits; wb_sel masks bytes.
  - 1 IN: ro, debounced input state.
  - 2 RISE_EN: rw, NIN bits.
  - 3 FALL_EN: rw, NIN bits.
  - 4 PENDING: read; writing 1 clears a bit (W1C), masked by wb_sel.
  - 5 OUT_SET: wo; OUT |= data. Reads 0.
  - 6 OUT_CLR: wo; OUT &= ~data. Reads 0.
  - 7 unmapped: acked, reads 0, writes ignored.
- Write effect is visible on gpio_o the cycle after the request, the same cycle as the ack.
- Input path per channel:
  - SYNC_STAGES flip-flop chain, then debouncer.
  - Debouncer keeps state s and counter c (width $clog2(DEBOUNCE_CYCLES+1)).
  - If synced input != s: c increments. When c reaches DEBOUNCE_CYCLES-1 on that cycle, s toggles and c becomes 0 on the next edge.
  - If synced input == s: c becomes 0. A glitch shorter than DEBOUNCE_CYCLES is fully rejected.
  - Latency from a pin change to IN = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Edge capture:
  - An accepted 0->1 sets PENDING[i] on the same edge s updates if RISE_EN[i]; an accepted 1->0 does so if FALL_EN[i].
  - Disabled edges are ignored, not latched.
  - Same-cycle W1C clear and hardware set on a bit: set wins.
  - Clearing an enable does not clear existing pending bits.
- irq is combinational from the PENDING flops (no extra latency) and stays high until all pending bits are cleared.
- Pins held at 1 through reset: after reset they produce an accepted rise after the normal latency. Firmware enables edges after init.
- Reset asserted mid-debounce or mid-transaction: all state returns to reset values and any in-flight ack is dropped.

Decomposition:
- Package wb_gpio_pkg:
  - Register index constants (REG_OUT=0 … REG_OUT_CLR=6) as an enum of width 3.
  - Function applying wb_sel byte masking to a 32-bit write.
- Sub-module gpio_debounce: one channel containing synchroniser, debouncer and rise/fall strobes; parameters SYNC_STAGES and DEBOUNCE_CYCLES. Instantiated NIN times with generate.
- Top level holds the register file, bus logic and irq.

Test Plan (NIN=4, NOUT=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Output access:
  - Write OUT=0xA, sel=0xF -> gpio_o=0xA.
  - Then OUT_SET=0x1 -> gpio_o=0xB; OUT_CLR=0x8 -> gpio_o=0x3.
  - Read OUT -> 0x3. Each access acked exactly 1 cycle after stb.
- Byte select: write OUT=0xFFFFFFFF with sel=0x2 -> gpio_o unchanged (0x3). Write with sel=0x1 -> gpio_o=0xF.
- Debounce:
  - gpio_i[0] pulses high for 3 cycles -> IN stays 0, PENDING=0.
  - gpio_i[0] held high -> IN[0]=1 exactly 6 cycles after the pin edge.
- Edge interrupts:
  - RISE_EN=0x1, FALL_EN=0x2. Accepted rise on ch0 -> PENDING=0x1, irq=1.
  - Accepted rise on ch1 -> PENDING unchanged. Accepted fall on ch1 -> PENDING=0x3.
  - W1C 0x1 -> PENDING=0x2, irq=1. W1C 0x2 -> irq=0.
- Set-vs-clear collision: time a W1C of bit0 to land on the same edge as a ch0 accepted rise -> PENDING[0]=1 after that edge.
- Pipelined burst and reset:
  - 4 back-to-back reads (IN, RISE_EN, PENDING, idx 7) -> 4 consecutive acks with correct data; idx 7 returns 0.
  - Assert rst mid-burst -> wb_ack=0 the next cycle, gpio_o=0, irq=0.
